// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between execute and write-back.
// Runs one Wishbone pipelined cycle per load/store, steers bytes onto the
// correct lanes, extends load results and reports misalignment or timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [1:0]  i_width,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_reg_idx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_reg_we,
    output logic [3:0]  o_reg_idx,
    output logic [31:0] o_load_data,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        req_bad;
    logic        on_bus;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  width_q;
    logic [1:0]  lane_q;
    logic        done_nxt;
    logic        err_nxt;
    logic        rwe_nxt;

    // Byte-lane enables for a given access width and address offset.
    function automatic logic [3:0] lane_sel(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            2'b00:   lane_sel = 4'b0001 << lo;
            2'b01:   lane_sel = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Store data replicated so the slave finds it on whichever lane is selected.
    function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // Move the addressed lane down to the LSBs and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [1:0] width, input logic [1:0] lo,
                                                input logic sgn, input logic [31:0] d);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {lo, 3'b000};
        h  = lo[1] ? d[31:16] : d[15:0];
        case (width)
            2'b00:   load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_extend = {{16{sgn & h[15]}}, h};
            default: load_extend = d;
        endcase
    endfunction

    assign req_bad = (i_width == 2'b11) ||
                     (i_width == 2'b01 && i_addr[0]) ||
                     (i_width == 2'b10 && i_addr[1:0] != 2'b00);
    assign on_bus  = (state == REQ) || (state == WAIT);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; an ack always wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = req_bad ? DONE : REQ;
            REQ: begin
                if (i_wb_ack || tmo_hit) state_nxt = DONE;
                else if (!i_wb_stall)    state_nxt = WAIT;
            end
            WAIT: if (i_wb_ack || tmo_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result flags for the cycle about to enter DONE.
    always_comb begin
        done_nxt = (state_nxt == DONE);
        err_nxt  = 1'b0;
        rwe_nxt  = 1'b0;
        if (state == IDLE && i_start && req_bad)
            err_nxt = 1'b1;
        if (on_bus && state_nxt == DONE) begin
            err_nxt = !i_wb_ack;
            rwe_nxt = i_wb_ack && !we_q;
        end
    end

    // Registered outputs, driven from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_reg_we    <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_load_data <= 32'd0;
        end else begin
            o_busy   <= (state_nxt != IDLE);
            o_done   <= done_nxt;
            o_error  <= err_nxt;
            o_reg_we <= rwe_nxt;
            o_wb_cyc <= (state_nxt == REQ) || (state_nxt == WAIT);
            o_wb_stb <= (state_nxt == REQ);
            if (rwe_nxt)
                o_load_data <= load_extend(width_q, lane_q, signed_q, i_wb_data);
        end
    end

    // Timeout counter: zero while idle, so it starts from zero on REQ entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          tmo_cnt <= 16'd0;
        else if (on_bus)     tmo_cnt <= tmo_cnt + 16'd1;
        else                 tmo_cnt <= 16'd0;
    end

    // Request capture; bus-side fields stay frozen for the whole cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            width_q   <= 2'b00;
            lane_q    <= 2'b00;
            o_reg_idx <= 4'd0;
            o_wb_addr <= 32'd0;
            o_wb_data <= 32'd0;
            o_wb_we   <= 1'b0;
            o_wb_sel  <= 4'd0;
        end else if (state == IDLE && i_start) begin
            we_q      <= i_we;
            signed_q  <= i_signed;
            width_q   <= i_width;
            lane_q    <= i_addr[1:0];
            o_reg_idx <= i_reg_idx;
            if (!req_bad) begin
                o_wb_addr <= {i_addr[31:2], 2'b00};
                o_wb_data <= lane_data(i_width, i_data);
                o_wb_we   <= i_we;
                o_wb_sel  <= lane_sel(i_width, i_addr[1:0]);
            end
        end
    end

endmodule
